// File: rtl/mskaes_round_ctrl_pkg.sv
// Shared types and defaults for the masked AES round controller.
// Holds the FSM state encoding, default sizes and counter-width helper.
package mskaes_ctrl_pkg;

  localparam int AES_NROUNDS = 10;
  localparam int SB_LAT_DEF  = 3;
  localparam int CNT_W       = $clog2(SB_LAT_DEF);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SB   = 3'd2,
    WAIT = 3'd3,
    LIN  = 3'd4,
    OUT  = 3'd5,
    CLR  = 3'd6
  } state_e;

  // SB_LAT=2 loads a count of 0, which still needs one bit.
  function automatic int cnt_width(input int lat);
    return (lat > 2) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/mskaes_round_ctrl_if.sv
// Handshake bundle of the round controller: block in, block out, randomness.
// master = controller side, slave = surrounding datapath / testbench.
interface mskaes_round_ctrl_if;

  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;
  logic rnd_req;
  logic rnd_valid;

  modport master (
    input  in_valid, out_ready, rnd_valid,
    output in_ready, out_valid, rnd_req
  );

  modport slave (
    output in_valid, out_ready, rnd_valid,
    input  in_ready, out_valid, rnd_req
  );

endinterface

// File: rtl/mskaes_round_ctrl_lat.sv
// Loadable down-counter with zero flag; times the S-box pipeline wait.
// Ports: clk, nrst (sync, active-low), load/val, dec, zero.
module mskaes_lat_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         load,
  input  logic [W-1:0] val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mskaes_round_ctrl.sv
// Round sequencer for a masked AES-128 SubBytes layer (control only).
// Ports: clk, nrst, io (handshakes), sb_feed, state_load, state_en,
//   mc_bypass, key_init, key_step, round, busy, done, state_clr.
// Optional macro MSKAES_CTRL_ZEROIZE_EN adds a one-cycle CLR state.
module mskaes_round_ctrl
  import mskaes_ctrl_pkg::*;
#(
  parameter int NROUNDS = AES_NROUNDS,
  parameter int SB_LAT  = SB_LAT_DEF,
  parameter int RW      = 4
) (
  input  logic                clk,
  input  logic                nrst,
  mskaes_round_ctrl_if.master io,
  output logic                sb_feed,
  output logic                state_load,
  output logic                state_en,
  output logic                mc_bypass,
  output logic                key_init,
  output logic                key_step,
  output logic [RW-1:0]       round,
  output logic                busy,
  output logic                done,
  output logic                state_clr
);

  localparam int CW = cnt_width(SB_LAT);

  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_LOAD = LOAD;
  localparam logic [2:0] S_SB   = SB;
  localparam logic [2:0] S_WAIT = WAIT;
  localparam logic [2:0] S_LIN  = LIN;
  localparam logic [2:0] S_OUT  = OUT;
  localparam logic [2:0] S_CLR  = CLR;

`ifdef MSKAES_CTRL_ZEROIZE_EN
  localparam logic [2:0] S_POST = S_CLR;
`else
  localparam logic [2:0] S_POST = S_IDLE;
`endif

  localparam logic [RW-1:0] LAST    = RW'(NROUNDS);
  localparam logic [CW-1:0] CNT_LD  = CW'(SB_LAT - 2);

  logic [2:0] st;
  logic       cnt_zero;
  logic       last_rnd;

  assign last_rnd = (round == LAST);

  // Counter is loaded on the feed so WAIT spans SB_LAT-1 cycles.
  mskaes_lat_cnt #(
    .W(CW)
  ) u_lat (
    .clk (clk),
    .nrst(nrst),
    .load(sb_feed),
    .val (CNT_LD),
    .dec (st == S_WAIT),
    .zero(cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!nrst) begin
      st    <= S_IDLE;
      round <= '0;
    end else begin
      unique case (st)
        S_IDLE: begin
          if (io.in_valid) begin
            st    <= S_LOAD;
            round <= RW'(1);
          end
        end
        S_LOAD: st <= S_SB;
        S_SB: begin
          if (io.rnd_valid) st <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt_zero) st <= S_LIN;
        end
        S_LIN: begin
          if (last_rnd) begin
            st <= S_OUT;
          end else begin
            st    <= S_SB;
            round <= round + RW'(1);
          end
        end
        S_OUT: begin
          if (io.out_ready) begin
            st    <= S_POST;
            round <= '0;
          end
        end
        S_CLR:   st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end

  assign io.in_ready  = (st == S_IDLE);
  assign io.rnd_req   = (st == S_SB);
  assign io.out_valid = (st == S_OUT);

  assign busy       = (st != S_IDLE);
  assign state_load = (st == S_LOAD);
  assign key_init   = (st == S_LOAD);
  assign sb_feed    = io.rnd_req & io.rnd_valid;
  assign state_en   = (st == S_LIN);
  assign key_step   = (st == S_LIN);
  assign mc_bypass  = (st == S_LIN) & last_rnd;
  assign done       = io.out_valid & io.out_ready;

`ifdef MSKAES_CTRL_ZEROIZE_EN
  assign state_clr = (st == S_CLR);
`else
  assign state_clr = 1'b0;
`endif

endmodule

// File: tb/tb_mskaes_round_ctrl.sv
// Self-checking bench for mskaes_round_ctrl.
// Expected event cycles are queued at block start and popped by a monitor.
module tb_mskaes_round_ctrl;

  localparam int NR  = 10;
  localparam int LAT = 3;
`ifdef MSKAES_CTRL_ZEROIZE_EN
  localparam int ZD = 1;
`else
  localparam int ZD = 0;
`endif

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       sb_feed, state_load, state_en, mc_bypass;
  logic       key_init, key_step, busy, done, state_clr;
  logic [3:0] round;

  mskaes_round_ctrl_if bus ();

  mskaes_round_ctrl #(
    .NROUNDS(NR),
    .SB_LAT (LAT),
    .RW     (4)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .io        (bus.master),
    .sb_feed   (sb_feed),
    .state_load(state_load),
    .state_en  (state_en),
    .mc_bypass (mc_bypass),
    .key_init  (key_init),
    .key_step  (key_step),
    .round     (round),
    .busy      (busy),
    .done      (done),
    .state_clr (state_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  bit ov_prev = 1'b0;

  int q_load[$], q_feed[$], q_en[$], q_byp[$];
  int q_ov[$], q_done[$], q_clr[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic int qleft();
    return q_load.size() + q_feed.size() + q_en.size() + q_byp.size()
         + q_ov.size() + q_done.size() + q_clr.size();
  endfunction

  task automatic clear_q();
    q_load.delete(); q_feed.delete(); q_en.delete(); q_byp.delete();
    q_ov.delete(); q_done.delete(); q_clr.delete();
  endtask

  // Monitor: every output event must match the next queued cycle.
  always @(negedge clk) begin
    int e;
    if (mon_en && nrst) begin
      if (state_load) begin
        e = (q_load.size() > 0) ? q_load.pop_front() : -1;
        chk("state_load", cyc, e);
        chk("key_init", key_init, 1);
      end
      if (sb_feed) begin
        e = (q_feed.size() > 0) ? q_feed.pop_front() : -1;
        chk("sb_feed", cyc, e);
      end
      if (state_en) begin
        e = (q_en.size() > 0) ? q_en.pop_front() : -1;
        chk("state_en", cyc, e);
        chk("key_step", key_step, 1);
      end
      if (mc_bypass) begin
        e = (q_byp.size() > 0) ? q_byp.pop_front() : -1;
        chk("mc_bypass", cyc, e);
      end
      if (bus.out_valid && !ov_prev) begin
        e = (q_ov.size() > 0) ? q_ov.pop_front() : -1;
        chk("out_valid", cyc, e);
      end
      if (done) begin
        e = (q_done.size() > 0) ? q_done.pop_front() : -1;
        chk("done", cyc, e);
      end
      if (state_clr) begin
        e = (q_clr.size() > 0) ? q_clr.pop_front() : -1;
        chk("state_clr", cyc, e);
      end
    end
    ov_prev = bus.out_valid;
  end

  task automatic push_exp(input int t0, input int stall, input int bp,
                          output int oc, output int td);
    int f;
    f = t0;
    q_load.push_back(t0 + 1);
    for (int r = 1; r <= NR; r++) begin
      f = t0 + 2 + (LAT + 1) * (r - 1) + ((r >= 3) ? stall : 0);
      q_feed.push_back(f);
      q_en.push_back(f + LAT);
    end
    q_byp.push_back(f + LAT);
    oc = f + LAT + 1;
    td = oc + bp;
    q_ov.push_back(oc);
    q_done.push_back(td);
    if (ZD == 1) q_clr.push_back(td + 1);
  endtask

  // Starts a block in the current cycle and runs until in_ready returns.
  task automatic run_block(input int stall, input int bp,
                           input bit toggle, input bit hold);
    int t0, oc, td, s0;
    chk("in_ready_start", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    t0 = cyc;
    s0 = t0 + 2 + 2 * (LAT + 1);
    push_exp(t0, stall, bp, oc, td);
    while (cyc < td + 1 + ZD) begin
      @(posedge clk);
      #1;
      if (hold) bus.in_valid = 1'b1;
      else if (toggle && cyc < td) bus.in_valid = (cyc % 2) == 1;
      else bus.in_valid = 1'b0;
      bus.rnd_valid = !(cyc >= s0 && cyc < s0 + stall);
      bus.out_ready = !(cyc >= oc && cyc < oc + bp);
      @(negedge clk);
      if (cyc < td + 1 + ZD) begin
        chk("in_ready_busy", bus.in_ready, 0);
        chk("busy", busy, 1);
      end else begin
        chk("in_ready_back", bus.in_ready, 1);
        chk("busy_idle", busy, 0);
        chk("round_idle", round, 0);
      end
      if (cyc >= s0 && cyc < s0 + stall) begin
        chk("rnd_req_stall", bus.rnd_req, 1);
        chk("round_stall", round, 3);
      end
      if (cyc >= oc && cyc < td) begin
        chk("ov_held", bus.out_valid, 1);
        chk("round_bp", round, NR);
        chk("done_bp", done, 0);
      end
    end
    chk("q_left", qleft(), 0);
  endtask

  initial begin
    int t0, oc, td;
    bus.in_valid  = 1'b0;
    bus.rnd_valid = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_rnd_req", bus.rnd_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_round", round, 0);
    chk("rst_sb_feed", sb_feed, 0);
    chk("rst_state_en", state_en, 0);
    chk("rst_load", state_load, 0);
    chk("rst_done", done, 0);
    chk("rst_clr", state_clr, 0);
    mon_en = 1'b1;

    run_block(0, 0, 1'b0, 1'b0);
    run_block(5, 0, 1'b0, 1'b0);
    run_block(0, 7, 1'b0, 1'b0);
    run_block(0, 0, 1'b1, 1'b0);
    run_block(0, 0, 1'b0, 1'b1);
    run_block(0, 0, 1'b0, 1'b0);

    // Reset during round 5 WAIT abandons the block.
    t0 = cyc;
    bus.in_valid = 1'b1;
    push_exp(t0, 0, 0, oc, td);
    while (cyc < t0 + 19) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
    end
    chk("round_pre_rst", round, 5);
    @(posedge clk);
    #1;
    nrst = 1'b0;
    clear_q();
    @(posedge clk);
    #1;
    nrst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_round", round, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (12) @(negedge clk);
    chk("post_rst_idle", bus.in_ready, 1);
    chk("q_left_end", qleft(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
